// File: rtl/serial_add_sched.sv
// Round-robin front end sharing one bit-serial adder between NREQ requesters.
// Operands are captured at the grant edge and summed LSB-first through a carry flop.
module serial_add_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH:0]          result,
  output logic [ID_W-1:0]         res_id
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             found;
  logic [ID_W-1:0]  win;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [1:0]       fa;
  logic [WIDTH-1:0] sum_nx;

  // {carry_out, sum} of a single-bit full adder
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Round-robin winner: first set req bit searching upward from ptr+1 with wrap
  always_comb begin
    found = 1'b0;
    win   = '0;
    win_a = '0;
    win_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + 1 + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
        win_a = op_a[idx*WIDTH +: WIDTH];
        win_b = op_b[idx*WIDTH +: WIDTH];
      end else begin
        found = found;
      end
    end
  end

  // One bit of the serial add; the new sum bit enters from the MSB side
  always_comb begin
    fa     = full_add(a_sh[0], b_sh[0], carry);
    sum_nx = {fa[0], sum_sh[WIDTH-1:1]};
  end

  // Scheduler FSM, serial datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= ID_W'(NREQ - 1);
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
      res_id    <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            a_sh   <= win_a;
            b_sh   <= win_b;
            carry  <= 1'b0;
            cnt    <= '0;
            ptr    <= win;
            res_id <= win;
            gnt    <= NREQ'(1'b1) << win;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          carry  <= fa[1];
          sum_sh <= sum_nx;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1'b1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result    <= {fa[1], sum_nx};
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Hold result until the consumer takes it; no grant in this state
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched: directed scenarios plus randomized
// traffic checked against a round-robin / plain-addition reference model.
module tb_serial_add_sched;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int OPW   = NREQ * WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [OPW-1:0]   op_a;
  logic [OPW-1:0]   op_b;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH:0]   result;
  logic [ID_W-1:0]  res_id;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int mptr      = NREQ - 1;
  int last_gcyc = 0;

  serial_add_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .res_id(res_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference round-robin pick: first requester after p, wrapping
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [WIDTH:0] model_sum(input int id);
    return {1'b0, op_a[id*WIDTH +: WIDTH]} + {1'b0, op_b[id*WIDTH +: WIDTH]};
  endfunction

  task automatic wait_grant(input int exp_id, input bit drop, input int exp_gap);
    logic [NREQ-1:0] exp_g;
    int prev;
    exp_g = '0;
    exp_g[exp_id] = 1'b1;
    prev = last_gcyc;
    for (int t = 0; t < 30; t++) begin
      step();
      if (gnt != '0) break;
    end
    n_checks++;
    if (gnt !== exp_g) begin
      n_fail++;
      $display("FAIL grant: gnt=%b expected %b", gnt, exp_g);
    end
    n_checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL grant_flags: busy=%b res_valid=%b expected busy=1 res_valid=0", busy, res_valid);
    end
    last_gcyc = cyc;
    if (exp_gap > 0) begin
      n_checks++;
      if (cyc - prev != exp_gap) begin
        n_fail++;
        $display("FAIL grant_gap: spacing=%0d expected %0d", cyc - prev, exp_gap);
      end
    end
    mptr = exp_id;
    if (drop) req[exp_id] = 1'b0;
  endtask

  task automatic finish_txn(input int exp_id, input logic [WIDTH:0] exp_sum);
    int n;
    bit bad;
    n = 0;
    bad = 1'b0;
    for (int t = 0; t < 3*WIDTH && !res_valid; t++) begin
      step();
      n++;
      if (gnt !== '0 || busy !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL txn_quiet: gnt or busy wrong during shift, gnt=%b busy=%b", gnt, busy);
    end
    n_checks++;
    if (n != WIDTH || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: res_valid=%b after %0d cycles, expected 1 after %0d", res_valid, n, WIDTH);
    end
    n_checks++;
    if (result !== exp_sum || res_id !== ID_W'(exp_id)) begin
      n_fail++;
      $display("FAIL result: result=%b id=%0d expected %b id=%0d", result, res_id, exp_sum, exp_id);
    end
    step();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: res_valid=%b busy=%b expected 0 0", res_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; op_a = '0; op_b = '0; res_ready = 1'b1;
    step();
    step();
    n_checks++;
    if ({gnt, busy, res_valid, result, res_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b busy=%b rv=%b result=%b id=%0d expected all 0",
               gnt, busy, res_valid, result, res_id);
    end
    reset = 1'b0;
    mptr = NREQ - 1;
  endtask

  task automatic test_single_add();
    req = 4'b0001;
    op_a[3:0] = 4'b0111;
    op_b[3:0] = 4'b0101;
    wait_grant(0, 1'b1, 0);
    finish_txn(0, 5'b01100);
  endtask

  task automatic test_overflow();
    req = 4'b0100;
    op_a[11:8] = 4'hF;
    op_b[11:8] = 4'hF;
    wait_grant(2, 1'b0, 0);
    finish_txn(2, 5'b11110);
    op_a[11:8] = 4'h0;
    op_b[11:8] = 4'h0;
    wait_grant(2, 1'b1, WIDTH + 2);
    finish_txn(2, 5'b00000);
  endtask

  task automatic test_round_robin();
    int exp_seq [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};
    logic [WIDTH:0] s;
    reset = 1'b1;
    step();
    reset = 1'b0;
    mptr = NREQ - 1;
    req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      op_a = OPW'($urandom);
      op_b = OPW'($urandom);
      s = model_sum(exp_seq[i]);
      wait_grant(exp_seq[i], 1'b0, (i == 0) ? 0 : WIDTH + 2);
      if (i == 7) req[1] = 1'b0;
      finish_txn(exp_seq[i], s);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] s;
    int n;
    req = 4'b0001;
    op_a = OPW'($urandom);
    op_b = OPW'($urandom);
    s = model_sum(0);
    res_ready = 1'b0;
    wait_grant(0, 1'b1, 0);
    req[1] = 1'b1;
    n = 0;
    for (int t = 0; t < 3*WIDTH && !res_valid; t++) begin
      step();
      n++;
    end
    n_checks++;
    if (n != WIDTH || result !== s || res_id !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_first: after %0d cycles result=%b id=%0d expected %b id=0 after %0d",
               n, result, res_id, s, WIDTH);
    end
    for (int t = 0; t < 3; t++) begin
      step();
      n_checks++;
      if (res_valid !== 1'b1 || result !== s || res_id !== 2'd0 || gnt !== '0) begin
        n_fail++;
        $display("FAIL bp_hold: rv=%b result=%b id=%0d gnt=%b expected 1 %b 0 0000",
                 res_valid, result, res_id, gnt, s);
      end
    end
    res_ready = 1'b1;
    step();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
      n_fail++;
      $display("FAIL bp_accept: rv=%b busy=%b gnt=%b expected 0 0 0000", res_valid, busy, gnt);
    end
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_next_grant: gnt=%b expected 0010", gnt);
    end
    mptr = 1;
    last_gcyc = cyc;
    req[1] = 1'b0;
    finish_txn(1, model_sum(1));
  endtask

  task automatic test_reset_mid();
    bit seen;
    req = 4'b0001;
    op_a = OPW'($urandom);
    op_b = OPW'($urandom);
    wait_grant(rr_pick(req, mptr), 1'b1, 0);
    step();
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({gnt, busy, res_valid, result, res_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: gnt=%b busy=%b rv=%b result=%b id=%0d expected all 0",
               gnt, busy, res_valid, result, res_id);
    end
    step();
    reset = 1'b0;
    mptr = NREQ - 1;
    seen = 1'b0;
    for (int t = 0; t < WIDTH + 3; t++) begin
      step();
      if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_discard: stale activity seen after reset, expected res_valid=0 busy=0");
    end
    req = 4'b1001;
    op_a[15:12] = 4'd6;
    op_b[15:12] = 4'd7;
    wait_grant(0, 1'b1, 0);
    finish_txn(0, model_sum(0));
    wait_grant(3, 1'b1, WIDTH + 2);
    finish_txn(3, 5'b01101);
  endtask

  task automatic test_operand_change();
    req = 4'b0001;
    op_a[3:0] = 4'h3;
    op_b[3:0] = 4'h1;
    wait_grant(0, 1'b1, 0);
    op_a[3:0] = 4'hA;
    finish_txn(0, 5'b00100);
  endtask

  task automatic test_random();
    int id;
    logic [WIDTH:0] s;
    for (int i = 0; i < 30; i++) begin
      req  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      op_a = OPW'($urandom);
      op_b = OPW'($urandom);
      id = rr_pick(req, mptr);
      s = model_sum(id);
      wait_grant(id, 1'($urandom), (i == 0) ? 0 : WIDTH + 2);
      op_a = OPW'($urandom);
      op_b = OPW'($urandom);
      finish_txn(id, s);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_operand_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
